// File: rtl/serial_sub_ctrl.sv
//------------------------------------------------------------------------------
// serial_sub_ctrl -- bit-serial subtraction controller around a single shared
//                    full-subtractor cell; optional zero flag via SERIAL_SUB_FLAGS_EN
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mFullSubtractor (
  input  logic iA,
  input  logic iB,
  input  logic iC,
  output logic oDiff,
  output logic oBorrow
);
  assign oDiff   = iA ^ iB ^ iC;
  assign oBorrow = (~iA & iB) | (~(iA ^ iB) & iC);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oReady,
  output logic             oBusy,
  output logic             oValid,
  input  logic             iAck,
  output logic [WIDTH-1:0] oDiff,
  output logic             oBorrow
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             oZero
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             bw;
  logic [CW-1:0]    cnt;

  // Result registers hold the last completed result through IDLE and RUN,
  // since d_sr is cleared and rebuilt while an operation is in flight.
  logic [WIDTH-1:0] res_diff;
  logic             res_borrow;

  logic cell_diff;
  logic cell_borrow;

  mFullSubtractor u_cell (
    .iA      (a_sr[0]),
    .iB      (b_sr[0]),
    .iC      (bw),
    .oDiff   (cell_diff),
    .oBorrow (cell_borrow)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      d_sr       <= '0;
      bw         <= 1'b0;
      cnt        <= '0;
      res_diff   <= '0;
      res_borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            a_sr  <= iA;
            b_sr  <= iB;
            d_sr  <= '0;
            bw    <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          d_sr <= {cell_diff, d_sr[WIDTH-1:1]};
          bw   <= cell_borrow;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            res_diff   <= {cell_diff, d_sr[WIDTH-1:1]};
            res_borrow <= cell_borrow;
            state      <= DONE;
          end
        end
        DONE: begin
          if (iAck) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  logic nz_sticky;
  logic zero_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      nz_sticky <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      if (state == IDLE && iStart) begin
        nz_sticky <= 1'b0;
      end else if (state == RUN) begin
        nz_sticky <= nz_sticky | cell_diff;
        if (cnt == LAST_BIT) begin
          zero_q <= ~(nz_sticky | cell_diff);
        end
      end
    end
  end

  assign oZero = zero_q;
`endif

  assign oReady  = (state == IDLE);
  assign oBusy   = (state == RUN);
  assign oValid  = (state == DONE);
  assign oDiff   = res_diff;
  assign oBorrow = res_borrow;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
//------------------------------------------------------------------------------
// tb_serial_sub_ctrl -- scoreboard bench: directed WIDTH=8 cases plus random
//                       sweeps at WIDTH 2, 8 and 32
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Directed-test instance, WIDTH=8
  logic       rst, start, ack;
  logic [7:0] a, b, diff;
  logic       ready, busy, valid, borrow;
`ifdef SERIAL_SUB_FLAGS_EN
  logic       zero;
`endif
  logic [8:0] sb8[$];

  serial_sub_ctrl #(.WIDTH(8)) u_dut (
    .iClk    (clk),
    .iRst    (rst),
    .iStart  (start),
    .iA      (a),
    .iB      (b),
    .oReady  (ready),
    .oBusy   (busy),
    .oValid  (valid),
    .iAck    (ack),
    .oDiff   (diff),
    .oBorrow (borrow)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .oZero   (zero)
`endif
  );

  task automatic launch(input logic [7:0] ia, input logic [7:0] ib);
    int n;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_start", ready, 1);
    a     = ia;
    b     = ib;
    start = 1'b1;
    sb8.push_back({(ia < ib), 8'(ia - ib)});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_op(input bit poke, input int hold);
    int lat;
    logic [8:0] e;
    lat = 0;
    while (!valid && lat < 40) begin
      if (busy) lat++;
      check("ready_low_in_run", ready, 0);
      if (poke) begin
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h01;
      end
      @(negedge clk);
    end
    check("busy_cycles", lat, 8);
    check("valid", valid, 1);
    e = sb8.pop_front();
    check("diff", diff, e[7:0]);
    check("borrow", borrow, e[8]);
`ifdef SERIAL_SUB_FLAGS_EN
    check("zero", zero, (e[7:0] == 8'h00));
`endif
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", valid, 1);
      check("hold_ready", ready, 0);
      check("hold_diff", diff, e[7:0]);
      check("hold_borrow", borrow, e[8]);
    end
    start = 1'b0;
    ack   = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ready_after_ack", ready, 1);
    check("valid_after_ack", valid, 0);
  endtask

  // Random sweeps, one instance per width
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int W = (gi == 0) ? 2 : (gi == 1) ? 8 : 32;
    logic         s_rst, s_start, s_ack;
    logic [W-1:0] s_a, s_b, s_diff;
    logic         s_ready, s_busy, s_valid, s_borrow;
`ifdef SERIAL_SUB_FLAGS_EN
    logic         s_zero;
`endif
    logic [W:0]   sb[$];
    bit           done = 1'b0;

    serial_sub_ctrl #(.WIDTH(W)) u_dut (
      .iClk    (clk),
      .iRst    (s_rst),
      .iStart  (s_start),
      .iA      (s_a),
      .iB      (s_b),
      .oReady  (s_ready),
      .oBusy   (s_busy),
      .oValid  (s_valid),
      .iAck    (s_ack),
      .oDiff   (s_diff),
      .oBorrow (s_borrow)
`ifdef SERIAL_SUB_FLAGS_EN
      ,
      .oZero   (s_zero)
`endif
    );

    initial begin
      s_rst = 1'b1; s_start = 1'b0; s_ack = 1'b0; s_a = '0; s_b = '0;
      repeat (2) @(negedge clk);
      s_rst = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        logic [31:0]  ra, rb;
        logic [W-1:0] ea, eb;
        logic [W:0]   full, e;
        int           n;
        ra = $urandom;
        rb = $urandom;
        if (i == 0) begin ra = 32'h0;        rb = 32'h1;        end
        if (i == 1) begin ra = 32'hFFFFFFFF; rb = 32'hFFFFFFFF; end
        if (i == 2) begin ra = 32'h0;        rb = 32'hFFFFFFFF; end
        ea   = ra[W-1:0];
        eb   = rb[W-1:0];
        full = {1'b0, ea} - {1'b0, eb};
        n = 0;
        while (!s_ready && n < 50) begin
          @(negedge clk);
          n++;
        end
        s_a = ea;
        s_b = eb;
        s_start = 1'b1;
        sb.push_back({(ea < eb), full[W-1:0]});
        @(negedge clk);
        s_start = 1'b0;
        n = 0;
        while (!s_valid && n < W + 10) begin
          @(negedge clk);
          n++;
        end
        check($sformatf("sw%0d_latency", W), n, W);
        e = sb.pop_front();
        check($sformatf("sw%0d_diff", W), s_diff, e[W-1:0]);
        check($sformatf("sw%0d_borrow", W), s_borrow, e[W]);
`ifdef SERIAL_SUB_FLAGS_EN
        check($sformatf("sw%0d_zero", W), s_zero, (e[W-1:0] == '0));
`endif
        repeat ($urandom_range(0, 2)) @(negedge clk);
        s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
      end
      done = 1'b1;
    end
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; ack = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_FLAGS_EN
    check("rst_zero", zero, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    launch(8'h5A, 8'h23); finish_op(1'b0, 0);
    launch(8'h00, 8'h01); finish_op(1'b0, 0);
    launch(8'hFF, 8'hFF); finish_op(1'b0, 0);
    launch(8'h80, 8'h7F); finish_op(1'b1, 5);

    // Abort in RUN: result registers must be cleared and no valid produced
    launch(8'h5A, 8'h23);
    repeat (2) @(negedge clk);
    check("pre_abort_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow, 0);
    void'(sb8.pop_back());
    repeat (10) @(negedge clk);
    check("abort_no_valid", valid, 0);
    launch(8'h10, 8'h20); finish_op(1'b0, 0);
    launch(8'hC3, 8'h3C); finish_op(1'b1, 2);

    n = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && n < 80000) begin
      @(negedge clk);
      n++;
    end
    check("sweeps_done", (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller: accepts two WIDTH-bit unsigned operands through a start/ready handshake and sequences a single `mFullSubtractor` instance over WIDTH clock cycles, LSB first, with a registered borrow chain. It returns the WIDTH-bit difference and final borrow through a valid/ack handshake. It is the area-minimal subtract path of the ALU, used where one full-subtractor cell must be time-shared across all bit positions.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- iClk  in  1  clock; all state updates on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iStart  in  1  request to start a subtraction; accepted only when oReady=1.
- iA  in  WIDTH  minuend; sampled on the accepting edge.
- iB  in  WIDTH  subtrahend; sampled on the accepting edge.
- oReady  out  1  high only in IDLE.
- oBusy  out  1  high only in RUN.
- oValid  out  1  high only in DONE; result outputs valid.
- iAck  in  1  consumer acknowledge; effective only while oValid=1.
- oDiff  out  WIDTH  iA − iB modulo 2^WIDTH.
- oBorrow  out  1  final borrow; 1 iff iA < iB (unsigned).
- oZero  out  1  present only with SERIAL_SUB_FLAGS_EN; 1 iff oDiff == 0.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Registers: shift regs rA, rB (WIDTH), result shift reg rD (WIDTH), borrow reg rBw, bit counter rCnt ($clog2(WIDTH+1) bits).
- IDLE: iStart=1 → load rA=iA, rB=iB, rD=0, rBw=0, rCnt=0, go RUN. iStart=0 → stay.
- RUN, each cycle: full subtractor sees iA=rA[0], iB=rB[0], iC=rBw; on the edge rA, rB shift right by 1, rD shifts right with the cell's oDiff entering at MSB, rBw ← cell oBorrow, rCnt ← rCnt+1. When rCnt == WIDTH−1 on that edge → DONE.
- DONE: oDiff=rD, oBorrow=rBw held stable. iAck=1 → IDLE on next edge; iAck=0 → stay indefinitely.
- iStart in RUN or DONE: ignored, no queuing.
- iAck outside DONE: ignored.
- The only arithmetic is in the shared cell; the controller adds no carry logic.
- Outputs in IDLE and RUN: oDiff and oBorrow keep the last completed result; they hold 0 after reset until the first completion.

## Timing
- Reset: oReady=1, oBusy=0, oValid=0, oDiff=0, oBorrow=0, oZero=0 on the edge after iRst is seen high. State, counter and shift registers are cleared.
- iRst has priority over all other inputs in every state. Reset mid-RUN aborts the operation and no oValid is produced.
- Latency: start accepted at edge E0 → RUN for edges E1..E_WIDTH → oValid=1 in the cycle after edge E_WIDTH (WIDTH cycles after acceptance).
- Minimum issue interval: WIDTH+2 cycles (RUN ×WIDTH, DONE ≥1, IDLE ≥1). No back-to-back start in the ack cycle.
- oReady, oBusy and oValid are mutually exclusive and registered from state, with no combinational path from inputs.

## Configuration
- SERIAL_SUB_FLAGS_EN defined: adds the oZero port and a sticky register that is cleared on load and ORs in each difference bit during RUN. oZero = ~sticky in DONE and holds through IDLE/RUN like oDiff.
- SERIAL_SUB_FLAGS_EN undefined: no oZero port and no flag register; all other behaviour is identical.

## Test plan
- WIDTH=8, iA=0x5A, iB=0x23, iStart pulse → oBusy for exactly 8 cycles, then oValid=1, oDiff=0x37, oBorrow=0.
- iA=0x00, iB=0x01 → oDiff=0xFF, oBorrow=1; iA=0xFF, iB=0xFF → oDiff=0x00, oBorrow=0 (oZero=1 with the macro).
- iStart re-asserted with iA=0x11, iB=0x01 during RUN and during DONE → ignored; first result unchanged; oReady returns only after iAck.
- Hold iAck=0 for 5 cycles in DONE → oValid, oDiff and oBorrow stable all 5 cycles; iAck=1 → oReady=1 on next cycle.
- iRst high at RUN cycle 3 → next cycle oReady=1, oBusy=0, oValid=0, oDiff=0, oBorrow=0; a new start then completes correctly.
- Random sweep of WIDTH ∈ {2, 8, 32}, 1000 operand pairs each → oDiff == (iA−iB) mod 2^WIDTH and oBorrow == (iA<iB), each with latency exactly WIDTH.
